scratchpad_stream_reader: RTL and testbench
===========================================

# scratchpad_stream_reader

Read-side DMA engine for the tensorcore scratchpad. It drives the scratchpad's Port A read controls (`dma_rd_en`, `dma_read_pointer`) and turns the returned words into an AXI-Stream master burst toward the host. Its counterpart is the slave-stream writer that drives the `dma_wr_*` side. It hides the scratchpad's fixed read latency and absorbs `tready` backpressure using a credit-limited output FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width; matches the scratchpad.
- `PTR_WIDTH`, default 16: width of the read pointer and length.
- `RD_LATENCY`, default 2: cycles from `dma_rd_en` to valid `dma_rd_data`. One cycle is the address register and one is the SRAM.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be ≥ 2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `start_ptr` in PTR_WIDTH: first read pointer.
- `len` in PTR_WIDTH: word count; 0 is legal.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `dma_rd_en` out 1: scratchpad read strobe.
- `dma_read_pointer` out PTR_WIDTH: read pointer; valid while `dma_rd_en` is high.
- `dma_rd_data` in DATA_WIDTH: scratchpad read data.
- `dma_wr_en` in 1: writer strobe; used only under `SCRATCHPAD_RD_ERR_EN`.
- `m_axis_tdata` out DATA_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks the final beat.
- `err` out 1: sticky protocol error.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `start` with `len` ≠ 0 goes to ISSUE. It loads `ptr` = `start_ptr`, `issue_left` = `len`, `beats_left` = `len`.
  - `start` with `len` = 0 pulses `done` on the next cycle. `busy` stays low and no beats are sent.
- **ISSUE**
  - A read is issued when `issue_left` ≠ 0 and credits allow it (rule below). Issuing means `dma_rd_en`=1, `dma_read_pointer`=`ptr`, then `ptr`++ and `issue_left`--.
  - After the last issue, go to DRAIN.
- **Credit rule:** issue only if `inflight + fifo_count < FIFO_DEPTH`.
  - `inflight` counts reads issued but not yet returned.
  - Use registered counts only; a pop in the same cycle does not free a credit until the next cycle.
  - The FIFO therefore never overflows.
- **Return pipe:** an RD_LATENCY-deep valid shift register tracks each `dma_rd_en`. When the tracked bit emerges, capture `dma_rd_data` into the FIFO.
- **Output FIFO**
  - Registered output: `m_axis_tdata` and `m_axis_tvalid` come from the FIFO head.
  - A pop happens on `tvalid & tready`; `beats_left` decrements per pop.
  - `m_axis_tlast` = `tvalid & (beats_left == 1)`.
- **DRAIN:** wait until the handshake with `beats_left == 1` completes. Then go to IDLE and assert `done` for one cycle.
- `start` while `busy` is ignored.
- Pointer arithmetic is modulo 2^PTR_WIDTH: 0xFFFF+1 wraps to 0x0000.
- `tdata` and `tlast` are stable while `tvalid & !tready`. `tvalid` never drops without a handshake.
- Reset values: all outputs 0; state IDLE; counters and FIFO empty.
- An asynchronous reset mid-burst aborts the burst immediately with no `done`, and in-flight data is discarded.
- Reads and writes share the scratchpad address register. The system guarantees `dma_wr_en`=0 while `busy`.

## Timing
- `start` accepted in cycle 0. With back-to-back issue, `dma_rd_en` is high in cycles 1…`len`.
- Data for a read issued in cycle t enters the FIFO at the t+RD_LATENCY edge and first drives `tvalid` in cycle t+RD_LATENCY+1. With defaults, the first beat is in cycle 4.
- Sustained throughput is 1 beat/cycle with `tready`=1 when FIFO_DEPTH ≥ RD_LATENCY+2. The defaults meet this.
- `done` is asserted the cycle after the final handshake. `busy` falls in that same cycle.

## Configuration
- `SCRATCHPAD_RD_ERR_EN` defined:
  - `err` is set in the cycle after `dma_wr_en`=1 is seen while `busy`.
  - `err` is cleared when a `start` is accepted; it is otherwise sticky.
  - The burst continues regardless.
- `SCRATCHPAD_RD_ERR_EN` undefined: `err` is tied to 0 and `dma_wr_en` is unused.

## Test plan
- **Basic 8-word read:** `start_ptr`=0x0100, `len`=8, `tready`=1.
  - `dma_rd_en` high in cycles 1–8 with pointers 0x0100–0x0107.
  - `tvalid` high in cycles 4–11 with data in order; `tlast` only in cycle 11.
  - `done` in cycle 12.
- **Backpressure:** `len`=16, `tready` toggling 1-0 plus a 10-cycle low stretch.
  - No FIFO overflow (`inflight + fifo_count` ≤ 4 at all times).
  - `tdata` stable while stalled; all 16 words in order; exactly one `tlast`.
- **Wrap:** `start_ptr`=0xFFFE, `len`=4 → pointers 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Zero length and busy start:**
  - `len`=0 → `done` at cycle 1, no `dma_rd_en`, no `tvalid`.
  - `start` pulsed mid-burst is ignored; the beat count is unchanged.
- **Reset mid-burst:** `rst_n` low at beat 3 of 8.
  - All outputs 0 asynchronously; no `done`.
  - A following `len`=2 burst completes normally.
- **Error flag (`SCRATCHPAD_RD_ERR_EN` defined):**
  - `dma_wr_en` pulsed during a burst → `err`=1 from the next cycle and held through `done`.
  - `err` cleared on the next accepted `start`.
  - With the macro undefined, `err` stays 0.

Source files
------------

// File: rtl/scratchpad_stream_reader_if.sv
// AXI-Stream bundle carrying the reader's output burst toward the host.
// Handshake: a beat transfers on a rising edge where tvalid & tready; while tvalid is high and tready low, tdata/tlast hold and tvalid stays high.
interface scratchpad_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/scratchpad_stream_reader.sv
// Scratchpad read DMA: issues credit-limited reads on Port A and streams the words out as an AXI-Stream burst.
// Optional feature macro SCRATCHPAD_RD_ERR_EN: sticky err on a writer strobe seen while busy.
module scratchpad_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PTR_WIDTH-1:0]  start_ptr,
    input  logic [PTR_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  dma_rd_en,
    output logic [PTR_WIDTH-1:0]  dma_read_pointer,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    input  logic                  dma_wr_en,
    scratchpad_stream_reader_if.master m_axis,
    output logic                  err,
    output logic [1:0]            dbg_state
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  issue_left;
    logic [PTR_WIDTH-1:0]  beats_left;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [RD_LATENCY-1:0] vpipe;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic credit_ok;
    logic issue;
    logic ret;
    logic pop;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Credits use registered counts only, so a same-cycle pop never lets an extra read slip in.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
    assign issue     = (state == ISSUE) && (issue_left != '0) && credit_ok;
    assign ret       = vpipe[RD_LATENCY-1];
    assign pop       = m_axis.m_axis_tvalid & m_axis.m_axis_tready;

    assign dma_rd_en        = issue;
    assign dma_read_pointer = issue ? ptr : '0;

    assign m_axis.m_axis_tvalid = (fifo_count != '0);
    assign m_axis.m_axis_tdata  = m_axis.m_axis_tvalid ? mem[rd_idx] : '0;
    assign m_axis.m_axis_tlast  = m_axis.m_axis_tvalid && (beats_left == PTR_WIDTH'(1));

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (ret) mem[wr_idx] <= dma_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ptr        <= '0;
            issue_left <= '0;
            beats_left <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            vpipe      <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
        end else begin
            done <= 1'b0;
            vpipe[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
            inflight   <= inflight + CW'(issue) - CW'(ret);
            fifo_count <= fifo_count + CW'(ret) - CW'(pop);
            if (ret) wr_idx <= next_idx(wr_idx);
            if (pop) begin
                rd_idx     <= next_idx(rd_idx);
                beats_left <= beats_left - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            ptr        <= start_ptr;
                            issue_left <= len;
                            beats_left <= len;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        ptr        <= ptr + 1'b1;
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == PTR_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (beats_left == PTR_WIDTH'(1))) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCRATCHPAD_RD_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err <= 1'b0;
        end else if (busy && dma_wr_en) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_wr_en;
    assign unused_wr_en = dma_wr_en;
    assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_scratchpad_stream_reader.sv
// Bench for scratchpad_stream_reader: table of bursts with per-cycle timing, ordering, stall and credit checks.
module tb_scratchpad_stream_reader;
    localparam int DW = 32;
    localparam int PW = 16;
    localparam int DEPTH = 4;
`ifdef SCRATCHPAD_RD_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] start_ptr;
    logic [PW-1:0] len;
    logic          busy;
    logic          done;
    logic          dma_rd_en;
    logic [PW-1:0] dma_read_pointer;
    logic [DW-1:0] dma_rd_data;
    logic          dma_wr_en;
    logic          err;
    logic [1:0]    dbg_state;
    logic [DW-1:0] p1;

    scratchpad_stream_reader_if #(.DATA_WIDTH(DW)) axis_if ();

    scratchpad_stream_reader #(
        .DATA_WIDTH(DW), .PTR_WIDTH(PW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ptr(start_ptr), .len(len),
        .busy(busy), .done(done), .dma_rd_en(dma_rd_en), .dma_read_pointer(dma_read_pointer),
        .dma_rd_data(dma_rd_data), .dma_wr_en(dma_wr_en), .m_axis(axis_if.master),
        .err(err), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [PW-1:0] ptr_q[$];

    typedef struct {
        logic [PW-1:0] sp;
        logic [PW-1:0] n;
        int            mode;      // 0: tready=1, 1: toggle + long stall, 2: random
        int            exp_done;  // 0: do not check done cycle
        int            wr_cycle;  // 0: no writer strobe
        bit            busy_start;
        int            rst_beat;  // 0: no reset
    } vec_t;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad model: address register then SRAM, two cycles of latency.
    function automatic logic [DW-1:0] word_of(input logic [PW-1:0] p);
        return {p ^ 16'h5A5A, p};
    endfunction

    always @(posedge clk) begin
        p1          <= dma_rd_en ? word_of(dma_read_pointer) : 32'hBAD0_BAD0;
        dma_rd_data <= p1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {busy, done, dma_rd_en, dma_read_pointer, axis_if.m_axis_tvalid,
                axis_if.m_axis_tlast, axis_if.m_axis_tdata, err, dbg_state};
    endfunction

    task automatic run_burst(input vec_t v);
        int beats = 0, tlasts = 0, rds = 0, first_valid = -1, done_cycle = -1;
        int issued = 0, popped = 0, max_out = 0;
        bit prev_stall = 0, finished = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [PW-1:0] p;
        for (int i = 0; i < int'(v.n); i++) begin
            p = v.sp + PW'(i);
            exp_q.push_back(word_of(p));
            ptr_q.push_back(p);
        end
        @(negedge clk);
        axis_if.m_axis_tready = 1'b1;
        start = 1'b1; start_ptr = v.sp; len = v.n;
        @(negedge clk);
        start = 1'b0; start_ptr = '0; len = '0;
        for (int c = 1; c <= 300 && !finished; c++) begin
            if (c > 1) @(negedge clk);
            case (v.mode)
                1: axis_if.m_axis_tready = (c >= 8 && c <= 17) ? 1'b0 : logic'(c % 2);
                2: axis_if.m_axis_tready = logic'($urandom_range(0, 1));
                default: axis_if.m_axis_tready = 1'b1;
            endcase
            if (v.busy_start && c == 3) begin
                start = 1'b1; start_ptr = 16'h0AAA; len = 16'd3;
            end else if (v.busy_start && c == 4) begin
                start = 1'b0; start_ptr = '0; len = '0;
            end
            dma_wr_en = (c == v.wr_cycle);
            #1;
            if (c == 1) begin
                check("busy_c1", busy, v.n != 0);
                check("err_clr_c1", err, 1'b0);
            end
            if (v.wr_cycle != 0 && c == v.wr_cycle + 1) check("err_set", err, ERR_EN);
            if (v.rst_beat > 0 && axis_if.m_axis_tvalid && beats == v.rst_beat - 1) begin
                rst_n = 1'b0;
                #1;
                check("rst_async_outs", out_vec(), 64'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    check("rst_no_done", {done, busy}, 2'b00);
                end
                rst_n = 1'b1;
                exp_q.delete();
                ptr_q.delete();
                return;
            end
            if (dma_rd_en) begin
                rds++;
                issued++;
                if (ptr_q.size() != 0) check("rd_ptr", dma_read_pointer, ptr_q.pop_front());
                else check("rd_extra", 1'b1, 1'b0);
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (axis_if.m_axis_tvalid) begin
                if (first_valid < 0) first_valid = c;
                if (prev_stall)
                    check("stall_stable", {axis_if.m_axis_tvalid, axis_if.m_axis_tlast, axis_if.m_axis_tdata},
                          {1'b1, prev_last, prev_data});
                check("tlast", axis_if.m_axis_tlast, beats == int'(v.n) - 1);
                if (axis_if.m_axis_tready) begin
                    popped++;
                    beats++;
                    if (axis_if.m_axis_tlast) tlasts++;
                    if (exp_q.size() != 0) check("tdata", axis_if.m_axis_tdata, exp_q.pop_front());
                    else check("beat_extra", 1'b1, 1'b0);
                end
            end else if (prev_stall) begin
                check("tvalid_drop", 1'b0, 1'b1);
            end
            prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
            prev_data  = axis_if.m_axis_tdata;
            prev_last  = axis_if.m_axis_tlast;
            if (done) begin
                done_cycle = c;
                finished = 1'b1;
                check("err_at_done", err, (v.wr_cycle != 0) ? ERR_EN : 1'b0);
            end
        end
        check("done_seen", finished, 1'b1);
        if (v.exp_done != 0) check("done_cycle", done_cycle, v.exp_done);
        check("first_valid", first_valid, (v.n != 0) ? 4 : -1);
        check("beat_count", beats, v.n);
        check("rd_count", rds, v.n);
        check("tlast_count", tlasts, (v.n != 0) ? 1 : 0);
        check("credit_bound", max_out <= DEPTH, 1'b1);
        check("queue_empty", exp_q.size() + ptr_q.size(), 0);
        @(negedge clk);
        #1;
        check("after_done", {done, busy, axis_if.m_axis_tvalid}, 3'b000);
        exp_q.delete();
        ptr_q.delete();
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h0100, 16'd8,  0, 12, 0, 1'b0, 0};
        vecs[1]  = '{16'h0000, 16'd1,  0, 5,  0, 1'b0, 0};
        vecs[2]  = '{16'hFFFE, 16'd4,  0, 8,  0, 1'b0, 0};
        vecs[3]  = '{16'h1234, 16'd0,  0, 1,  0, 1'b0, 0};
        vecs[4]  = '{16'h0040, 16'd16, 1, 0,  0, 1'b0, 0};
        vecs[5]  = '{16'h0300, 16'd6,  0, 10, 0, 1'b1, 0};
        vecs[6]  = '{16'h0500, 16'd5,  2, 0,  0, 1'b0, 0};
        vecs[7]  = '{16'h0600, 16'd5,  0, 9,  3, 1'b0, 0};
        vecs[8]  = '{16'h0700, 16'd3,  0, 7,  0, 1'b0, 0};
        vecs[9]  = '{16'h0200, 16'd8,  0, 0,  0, 1'b0, 3};
        vecs[10] = '{16'h0010, 16'd2,  0, 6,  0, 1'b0, 0};

        rst_n = 1'b0;
        start = 1'b0; start_ptr = '0; len = '0;
        dma_wr_en = 1'b0;
        axis_if.m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", out_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_burst(vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
